// File: rtl/seg_scan_driver.sv
// Time-multiplexed multi-digit 7-segment driver with shadow capture, blink, hex glyphs and leading-zero blanking.
// Outputs are registered with 1 cycle latency. There is no backpressure: the scan free-runs.
module seg_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int SCAN_DIV    = 1000,
  parameter int BLINK_TICKS = 250,
  parameter int HEX_EN      = 0,
  parameter int LZB_EN      = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     en,
  input  logic [DIGITS-1:0]     blink,
  input  logic                  load,
  output logic [6:0]            seg_out,
  output logic [DIGITS-1:0]     dig_sel
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  localparam logic [6:0] SEG_DASH  = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  logic [4*DIGITS-1:0] sh_value;
  logic [DIGITS-1:0]   sh_en;
  logic [DIGITS-1:0]   sh_blink;

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [BW-1:0] blink_cnt;
  logic          phase;
  logic          tick;

  logic [3:0]        cur_code;
  logic              cur_en;
  logic              cur_blink;
  logic              cur_lz;
  logic [DIGITS-1:0] lz_vec;
  logic              lz_run;
  logic [DIGITS-1:0] sel_onehot;
  logic [6:0]        seg_nxt;
  logic [DIGITS-1:0] sel_nxt;

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    s = SEG_DASH;
    case (code)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = (HEX_EN != 0) ? 7'b1110111 : SEG_DASH;
      4'hB: s = (HEX_EN != 0) ? 7'b0011111 : SEG_DASH;
      4'hC: s = (HEX_EN != 0) ? 7'b1001110 : SEG_DASH;
      4'hD: s = (HEX_EN != 0) ? 7'b0111101 : SEG_DASH;
      4'hE: s = (HEX_EN != 0) ? 7'b1001111 : SEG_DASH;
      4'hF: s = (HEX_EN != 0) ? 7'b1000111 : SEG_DASH;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  assign tick = (cnt == CNT_LAST);

  // The display reads only the shadow copy, so a load landing on a slot
  // boundary shows up intact on the following output word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_value <= '0;
      sh_en    <= '0;
      sh_blink <= '0;
    end else if (load) begin
      sh_value <= value;
      sh_en    <= en;
      sh_blink <= blink;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      idx       <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end

  // lz_vec[d]: digit d and every digit above it hold code 0.
  always_comb begin
    lz_vec = '0;
    lz_run = 1'b1;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      lz_run    = lz_run & (sh_value[4*d +: 4] == 4'h0);
      lz_vec[d] = lz_run;
    end
  end

  always_comb begin
    cur_code   = 4'h0;
    cur_en     = 1'b0;
    cur_blink  = 1'b0;
    cur_lz     = 1'b0;
    sel_onehot = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (idx == IW'(d)) begin
        cur_code      = sh_value[4*d +: 4];
        cur_en        = sh_en[d];
        cur_blink     = sh_blink[d];
        cur_lz        = (d != 0) && lz_vec[d];
        sel_onehot[d] = 1'b1;
      end
    end
  end

  always_comb begin
    seg_nxt = decode(cur_code);
    if (!cur_en) begin
      seg_nxt = SEG_DASH;
    end else if (cur_blink && phase) begin
      seg_nxt = SEG_BLANK;
    end else if ((LZB_EN != 0) && cur_lz) begin
      seg_nxt = SEG_BLANK;
    end
    // Segments stay live through the dead-time cycle; only the select is gated.
    sel_nxt = (cnt == '0) ? '0 : sel_onehot;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out <= '0;
      dig_sel <= '0;
    end else begin
      seg_out <= seg_nxt;
      dig_sel <= sel_nxt;
    end
  end

endmodule
